// File: rtl/seg_shift_pkg.sv
// Shared types and constants for the serial display-shift receiver.
// Frame lengths of the two on-board shift chains.
package seg_shift_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_t;

   localparam int SEG_NBITS = 64;
   localparam int LED_NBITS = 16;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with a history flop for rising-edge detect.
// o_level is the synchronized input; o_rise pulses for one clk.
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic i_async,
   output logic o_level,
   output logic o_rise
);

   logic [STAGES-1:0] r_sync;
   logic              r_prev;

   // Shift the async input through the chain and keep last level.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_async};
         r_prev <= r_sync[STAGES-1];
      end
   end

   assign o_level = r_sync[STAGES-1];
   assign o_rise  = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/seg_shift_rx.sv
// Serial display-shift receiver: oversamples the shift lines,
// deserializes MSB-first and latches the frame on the PEN strobe.
module seg_shift_rx
   import seg_shift_pkg::*;
#(
   parameter int NBITS       = 64,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = $clog2(NBITS + 2)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             ser_clk,
   input  logic             ser_clr,
   input  logic             ser_do,
   input  logic             ser_pen,
   output logic [NBITS-1:0] par_data,
   output logic             frame_valid,
   output logic             frame_err,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             busy
);

   localparam logic [CNT_W-1:0] L_FULL = CNT_W'(NBITS);
   localparam logic [CNT_W-1:0] L_SAT  = CNT_W'(NBITS + 1);
   localparam logic [CNT_W-1:0] L_ONE  = CNT_W'(1);

   logic w_clk_lvl, w_clk_rise;
   logic w_pen_lvl, w_pen_rise;
   logic w_clr_lvl, w_clr_rise;
   logic w_unused;

   logic [SYNC_STAGES-1:0] r_do_dly;
   logic                   w_do_s;

   state_t           r_state;
   logic [NBITS-1:0] r_shift;
   logic [CNT_W-1:0] r_cnt;
   logic [NBITS-1:0] r_par;
   logic             r_fv;
   logic             r_fe;
   logic             r_busy;

   logic [NBITS-1:0] w_shift_nx;
   logic [CNT_W-1:0] w_cnt_nx;

   sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
      .clk     (clk),
      .rstn    (rstn),
      .i_async (ser_clk),
      .o_level (w_clk_lvl),
      .o_rise  (w_clk_rise)
   );

   sync_edge #(.STAGES(SYNC_STAGES)) u_sync_pen (
      .clk     (clk),
      .rstn    (rstn),
      .i_async (ser_pen),
      .o_level (w_pen_lvl),
      .o_rise  (w_pen_rise)
   );

   sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clr (
      .clk     (clk),
      .rstn    (rstn),
      .i_async (ser_clr),
      .o_level (w_clr_lvl),
      .o_rise  (w_clr_rise)
   );

   // Only the edges of clk/pen and the level of clr drive the logic.
   assign w_unused = ^{w_clk_lvl, w_pen_lvl, w_clr_rise};

   // Delay data by the synchronizer depth so it lines up with ser_clk.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_do_dly <= '0;
      end else begin
         r_do_dly <= {r_do_dly[SYNC_STAGES-2:0], ser_do};
      end
   end

   assign w_do_s     = r_do_dly[SYNC_STAGES-1];
   assign w_shift_nx = {r_shift[NBITS-2:0], w_do_s};
   assign w_cnt_nx   = (r_cnt == L_SAT) ? r_cnt : r_cnt + L_ONE;

   // Frame FSM: shift on clk edges, latch one cycle after a pen edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_cnt   <= '0;
         r_par   <= '0;
         r_fv    <= 1'b0;
         r_fe    <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_fv <= 1'b0;
         r_fe <= 1'b0;
         if (!w_clr_lvl) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_state <= IDLE;
            r_busy  <= 1'b0;
         end else begin
            unique case (r_state)
               IDLE, SHIFT: begin
                  if (w_clk_rise) begin
                     r_shift <= w_shift_nx;
                     r_cnt   <= w_cnt_nx;
                  end
                  if (w_pen_rise) begin
                     r_state <= LATCH;
                     r_busy  <= 1'b0;
                  end else if (w_clk_rise) begin
                     r_state <= SHIFT;
                     r_busy  <= 1'b1;
                  end
               end
               LATCH: begin
                  r_par <= r_shift;
                  r_fv  <= (r_cnt == L_FULL);
                  r_fe  <= (r_cnt != L_FULL);
                  // A bit arriving during the latch starts the next frame.
                  if (w_clk_rise) begin
                     r_shift <= w_shift_nx;
                     r_cnt   <= L_ONE;
                     r_state <= SHIFT;
                     r_busy  <= 1'b1;
                  end else begin
                     r_cnt   <= '0;
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign par_data    = r_par;
   assign frame_valid = r_fv;
   assign frame_err   = r_fe;
   assign bit_cnt     = r_cnt;
   assign busy        = r_busy;

endmodule
